axil_csr_bank: RTL and testbench
================================

// Module: axil_csr_bank
// PURPOSE
//  Register bank on the downstream side of the AXI-lite register read/write adapters.
//  Decodes the reg_rd_*/reg_wr_* register interface into NUM_REGS words:
//    CTRL (idx 0), STATUS (idx 1), GP general-purpose words (idx 2..NUM_REGS-1).
//  Returns read data with a configurable latency using the wait/ack protocol.
//  Drives a start/done/irq handshake toward the accelerator core.
// PARAMETERS
//  DATA_WIDTH   32  register and data width (bits)
//  ADDR_WIDTH   40  byte address width
//  STRB_WIDTH   4   write byte strobes, DATA_WIDTH/8
//  NUM_REGS     16  words in the bank; power of 2, >=4
//  BASE_ADDR    0   byte address of word 0; aligned to NUM_REGS*4
//  RD_LATENCY   1   cycles from read accept to reg_rd_ack; range 1..8
// PORTS
//  clk          in   1                        clock
//  rstn         in   1                        synchronous active-low reset
//  reg_rd_addr  in   ADDR_WIDTH               read byte address, stable while reg_rd_en
//  reg_rd_en    in   1                        read request, level, held until ack
//  reg_rd_data  out  DATA_WIDTH               read data, valid only when reg_rd_ack=1
//  reg_rd_wait  out  1                        read in progress, ack not yet given
//  reg_rd_ack   out  1                        one-cycle read completion
//  reg_wr_addr  in   ADDR_WIDTH               write byte address
//  reg_wr_data  in   DATA_WIDTH               write data
//  reg_wr_strb  in   STRB_WIDTH               byte enables
//  reg_wr_en    in   1                        write request
//  reg_wr_wait  out  1                        constant 0
//  reg_wr_ack   out  1                        equals reg_wr_en (same cycle)
//  start_o      out  1                        one-cycle start pulse to core
//  busy_i       in   1                        core busy
//  done_i       in   1                        core done pulse
//  irq_o        out  1                        level interrupt, registered
//  gp_o         out  (NUM_REGS-2)*DATA_WIDTH  GP words, flat; word 2 in the LSBs
// BEHAVIOUR
//  Reset (rstn=0 at a clk edge):
//    - all registers, outputs, and the read FSM go to 0/IDLE.
//    - an in-flight read is dropped; no ack follows.
//  Decode:
//    - off = addr - BASE_ADDR; idx = off[log2(NUM_REGS)+1:2].
//    - out of range if off >= NUM_REGS*4: reads return 0, writes are ignored, ack is still given.
//    - off[1:0] is ignored.
//  Register map:
//    - CTRL:   bit0 START (write-1 pulses, reads 0); bit1 IEN (R/W). Other bits read 0.
//    - STATUS (RO except W1C):
//        bit0 BUSY = busy_i, live.
//        bit1 DONE, sticky: set by done_i, cleared by writing 1 with strb[0].
//        bit2 ERR, sticky: set on START while busy_i=1, cleared by writing 1.
//      done_i set wins over W1C in the same cycle; same rule for ERR.
//    - GP: R/W with per-byte strobes.
//  Write path:
//    - reg_wr_en=1 at edge t updates the register at t (visible from t+1).
//    - Write to CTRL with bit0=1 and strb[0]=1 at t:
//        busy_i=0 -> start_o=1 in cycle t+1 only.
//        busy_i=1 -> no start_o; set ERR.
//  Read FSM: IDLE -> CNT -> ACK -> IDLE.
//    - IDLE: reg_rd_en=1 at edge t captures the word and moves to CNT. Data is the pre-write value
//      if a write to the same word hits edge t.
//    - reg_rd_wait=1 from cycle t through t+RD_LATENCY-1.
//    - reg_rd_ack=1 and reg_rd_data valid in cycle t+RD_LATENCY (ACK state), then IDLE.
//    - reg_rd_en low in CNT (requester timeout): abort to IDLE, no ack.
//    - In ACK, reg_rd_en is ignored; a new read is accepted no earlier than cycle t+RD_LATENCY+1.
//    - reg_rd_data=0 outside ACK.
//  irq_o <= DONE & IEN (1 cycle after either changes).
//  Read-only bits ignore writes. Reads have no side effects.
// TESTING
//  T1 reset: after rstn low 2 cycles -> all outputs 0; reads of idx 0..15 return 0.
//  T2 GP: write 0xA5A5_1234 strb 4'b0101 to 0x08, then read 0x08 ->
//     data 0x00A5_0034; ack exactly RD_LATENCY cycles after en; wait high before it.
//  T3 start: busy_i=0, write CTRL=0x3 -> start_o one cycle;
//     done_i pulse -> STATUS=0x2, irq_o=1 next cycle;
//     W1C 0x2 -> STATUS=0, irq_o=0.
//  T4 error: busy_i=1, write CTRL=0x1 -> no start_o; STATUS=0x5.
//     done_i and W1C of DONE in the same cycle -> DONE stays 1.
//  T5 abort: RD_LATENCY=4, drop reg_rd_en at cycle 2 -> no ack; next read completes normally.
//  T6 out of range: read BASE_ADDR+0x40 -> ack, data 0; write there -> no GP change.

Source files
------------

// File: rtl/axil_csr_bank.sv
`default_nettype none
// ============================================================================
// axil_csr_bank : CTRL/STATUS/GP register bank behind the reg_rd/reg_wr port
// Revision      : 1.0
// ============================================================================
module axil_csr_bank #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 40,
   parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
   parameter int                    NUM_REGS   = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    RD_LATENCY = 1
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic [ADDR_WIDTH-1:0]            reg_rd_addr,
   input  logic                             reg_rd_en,
   output logic [DATA_WIDTH-1:0]            reg_rd_data,
   output logic                             reg_rd_wait,
   output logic                             reg_rd_ack,
   input  logic [ADDR_WIDTH-1:0]            reg_wr_addr,
   input  logic [DATA_WIDTH-1:0]            reg_wr_data,
   input  logic [STRB_WIDTH-1:0]            reg_wr_strb,
   input  logic                             reg_wr_en,
   output logic                             reg_wr_wait,
   output logic                             reg_wr_ack,
   output logic                             start_o,
   input  logic                             busy_i,
   input  logic                             done_i,
   output logic                             irq_o,
   output logic [(NUM_REGS-2)*DATA_WIDTH-1:0] gp_o
);

   localparam int         IDX_W    = $clog2(NUM_REGS);
   localparam int         NUM_GP   = NUM_REGS - 2;
   localparam logic [3:0] CNT_INIT = (RD_LATENCY > 1) ? 4'(RD_LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_CNT  = 2'd1,
      RD_ACK  = 2'd2
   } rd_state_t;

   rd_state_t             rd_state_q, rd_state_d;
   logic [3:0]            rd_cnt_q, rd_cnt_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  ien_q, ien_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  start_q, start_d;
   logic                  irq_q, irq_d;
   logic [DATA_WIDTH-1:0] gp_q [NUM_GP];
   logic [DATA_WIDTH-1:0] gp_d [NUM_GP];

   logic [ADDR_WIDTH-1:0] rd_word, wr_word;
   logic [IDX_W-1:0]      rd_idx, wr_idx;
   logic                  rd_in_range, wr_hit;
   logic                  ctrl_wr, stat_wr, start_req;
   logic [DATA_WIDTH-1:0] rd_value;

   // Word offsets: an address below the base wraps to a huge offset and falls out of range.
   always_comb begin
      rd_word     = (reg_rd_addr - BASE_ADDR) >> 2;
      wr_word     = (reg_wr_addr - BASE_ADDR) >> 2;
      rd_in_range = rd_word < ADDR_WIDTH'(NUM_REGS);
      wr_hit      = reg_wr_en && (wr_word < ADDR_WIDTH'(NUM_REGS));
      rd_idx      = rd_word[IDX_W-1:0];
      wr_idx      = wr_word[IDX_W-1:0];
   end

   always_comb begin
      rd_value = '0;
      if (rd_in_range) begin
         case (rd_idx)
            IDX_W'(0): rd_value[1] = ien_q;
            IDX_W'(1): begin
               rd_value[0] = busy_i;
               rd_value[1] = done_q;
               rd_value[2] = err_q;
            end
            default:   rd_value = gp_q[rd_idx - IDX_W'(2)];
         endcase
      end
   end

   // Sticky status bits: a same-cycle set beats the write-1-to-clear.
   always_comb begin
      ctrl_wr   = wr_hit && (wr_idx == IDX_W'(0)) && reg_wr_strb[0];
      stat_wr   = wr_hit && (wr_idx == IDX_W'(1)) && reg_wr_strb[0];
      start_req = ctrl_wr && reg_wr_data[0];
      ien_d     = ctrl_wr ? reg_wr_data[1] : ien_q;
      start_d   = start_req && !busy_i;
      done_d    = done_i | (done_q & ~(stat_wr & reg_wr_data[1]));
      err_d     = (start_req & busy_i) | (err_q & ~(stat_wr & reg_wr_data[2]));
      irq_d     = done_q & ien_q;
      for (int i = 0; i < NUM_GP; i++) begin
         gp_d[i] = gp_q[i];
         if (wr_hit && (wr_idx == IDX_W'(i + 2))) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
               if (reg_wr_strb[b]) gp_d[i][8*b +: 8] = reg_wr_data[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      rd_state_d  = rd_state_q;
      rd_cnt_d    = rd_cnt_q;
      rd_data_d   = rd_data_q;
      reg_rd_wait = 1'b0;
      reg_rd_ack  = 1'b0;
      reg_rd_data = '0;
      case (rd_state_q)
         RD_IDLE: begin
            if (reg_rd_en) begin
               reg_rd_wait = 1'b1;
               rd_data_d   = rd_value;
               rd_cnt_d    = CNT_INIT;
               rd_state_d  = (RD_LATENCY == 1) ? RD_ACK : RD_CNT;
            end
         end
         RD_CNT: begin
            reg_rd_wait = 1'b1;
            if (!reg_rd_en)          rd_state_d = RD_IDLE;
            else if (rd_cnt_q == '0) rd_state_d = RD_ACK;
            else                     rd_cnt_d   = rd_cnt_q - 4'd1;
         end
         RD_ACK: begin
            reg_rd_ack  = 1'b1;
            reg_rd_data = rd_data_q;
            rd_state_d  = RD_IDLE;
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_state_q <= RD_IDLE;
         rd_cnt_q   <= '0;
         rd_data_q  <= '0;
         ien_q      <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         start_q    <= 1'b0;
         irq_q      <= 1'b0;
         for (int i = 0; i < NUM_GP; i++) gp_q[i] <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_data_q  <= rd_data_d;
         ien_q      <= ien_d;
         done_q     <= done_d;
         err_q      <= err_d;
         start_q    <= start_d;
         irq_q      <= irq_d;
         for (int i = 0; i < NUM_GP; i++) gp_q[i] <= gp_d[i];
      end
   end

   generate
      for (genvar g = 0; g < NUM_GP; g++) begin : g_gp
         assign gp_o[g*DATA_WIDTH +: DATA_WIDTH] = gp_q[g];
      end
   endgenerate

   assign reg_wr_wait = 1'b0;
   assign reg_wr_ack  = reg_wr_en;
   assign start_o     = start_q;
   assign irq_o       = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_csr_bank.sv
`default_nettype none
// ============================================================================
// tb_axil_csr_bank : randomized self-checking bench with a behavioural model
// Revision         : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_axil_csr_bank;
   localparam int             DW = 32;
   localparam int             AW = 40;
   localparam int             NR = 16;
   localparam int             NG = NR - 2;
   localparam int             RD_LAT = 4;
   localparam logic [AW-1:0]  BASE = 40'h00_0000_1000;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic [AW-1:0]   rd_addr = '0, wr_addr = '0;
   logic            rd_en = 1'b0, wr_en = 1'b0;
   logic [DW-1:0]   wr_data = '0;
   logic [3:0]      wr_strb = '0;
   logic            busy = 1'b0, done_in = 1'b0;
   logic [DW-1:0]   rd_data;
   logic            rd_wait, rd_ack, wr_wait, wr_ack, start_o, irq_o;
   logic [NG*DW-1:0] gp_o;

   // Behavioural model of the register bank
   bit            m_ien, m_done, m_err, m_start, m_irq;
   logic [DW-1:0] m_gp [NG];

   int n_cmp = 0;
   int n_err = 0;

   axil_csr_bank #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(4), .NUM_REGS(NR),
      .BASE_ADDR(BASE), .RD_LATENCY(RD_LAT)
   ) dut (
      .clk(clk), .rstn(rstn),
      .reg_rd_addr(rd_addr), .reg_rd_en(rd_en), .reg_rd_data(rd_data),
      .reg_rd_wait(rd_wait), .reg_rd_ack(rd_ack),
      .reg_wr_addr(wr_addr), .reg_wr_data(wr_data), .reg_wr_strb(wr_strb),
      .reg_wr_en(wr_en), .reg_wr_wait(wr_wait), .reg_wr_ack(wr_ack),
      .start_o(start_o), .busy_i(busy), .done_i(done_in), .irq_o(irq_o), .gp_o(gp_o)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      longint off = longint'(a) - longint'(BASE);
      int idx;
      if (off < 0 || off >= NR * 4) return '0;
      idx = int'(off / 4);
      if (idx == 0) return {30'd0, m_ien, 1'b0};
      if (idx == 1) return {29'd0, m_err, m_done, busy};
      return m_gp[idx-2];
   endfunction

   function automatic logic [NG*DW-1:0] exp_gp();
      logic [NG*DW-1:0] r;
      for (int i = 0; i < NG; i++) r[i*DW +: DW] = m_gp[i];
      return r;
   endfunction

   // Advance one clock edge; the model applies the register rules to the inputs seen at that edge.
   task automatic tick();
      bit     n_ien, n_done, n_er, n_start;
      longint off;
      int     idx;
      @(posedge clk);
      if (!rstn) begin
         m_ien = 0; m_done = 0; m_err = 0; m_start = 0; m_irq = 0;
         for (int i = 0; i < NG; i++) m_gp[i] = '0;
      end else begin
         n_ien = m_ien; n_done = m_done; n_er = m_err; n_start = 0;
         off = longint'(wr_addr) - longint'(BASE);
         if (wr_en && off >= 0 && off < NR * 4) begin
            idx = int'(off / 4);
            if (idx == 0 && wr_strb[0]) begin
               n_ien = wr_data[1];
               if (wr_data[0]) begin
                  if (busy) n_er = 1; else n_start = 1;
               end
            end else if (idx == 1 && wr_strb[0]) begin
               if (wr_data[1]) n_done = 0;
               if (wr_data[2]) n_er = 0;
            end else if (idx >= 2) begin
               for (int b = 0; b < 4; b++)
                  if (wr_strb[b]) m_gp[idx-2][8*b +: 8] = wr_data[8*b +: 8];
            end
         end
         if (done_in) n_done = 1;
         m_irq = m_done & m_ien;
         m_ien = n_ien; m_done = n_done; m_err = n_er; m_start = n_start;
      end
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                           output bit ack, output bit wt);
      wr_addr = a; wr_data = d; wr_strb = s; wr_en = 1'b1;
      #1;
      ack = wr_ack; wt = wr_wait;
      tick();
      wr_en = 1'b0;
   endtask

   // Runs one read; reports data at ack, cycles from accept to ack (-1 = none) and whether wait held.
   task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat,
                          output bit wait_ok);
      rd_addr = a; rd_en = 1'b1; lat = -1; wait_ok = 1; d = '0;
      #1;
      for (int c = 0; c < 20; c++) begin
         if (rd_ack) begin lat = c; d = rd_data; break; end
         if (!rd_wait) wait_ok = 0;
         tick();
      end
      rd_en = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      logic [DW-1:0] d; int lat; bit wok;
      rstn = 1'b0; tick(); tick(); rstn = 1'b1;
      n_cmp++; if ({start_o, irq_o, rd_ack, rd_wait, wr_wait} !== 5'b0) begin
         n_err++; $display("FAIL reset_outs: got %b want 00000", {start_o, irq_o, rd_ack, rd_wait, wr_wait}); end
      n_cmp++; if (gp_o !== '0) begin n_err++; $display("FAIL reset_gp: got %h want 0", gp_o); end
      n_cmp++; if (rd_data !== '0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rd_data); end
      for (int i = 0; i < NR; i++) begin
         do_read(BASE + AW'(4 * i), d, lat, wok);
         n_cmp++; if (d !== '0 || lat != RD_LAT) begin
            n_err++; $display("FAIL reset_read idx %0d: got %h lat %0d want 0 lat %0d", i, d, lat, RD_LAT); end
      end
   endtask

   task automatic test_gp();
      logic [DW-1:0] d; int lat; bit wok, ack, wt;
      do_write(BASE + 40'h8, 32'hA5A5_1234, 4'b0101, ack, wt);
      n_cmp++; if (ack !== 1'b1 || wt !== 1'b0) begin
         n_err++; $display("FAIL gp_wr_ack: got ack %b wait %b want 1 0", ack, wt); end
      n_cmp++; if (gp_o[DW-1:0] !== 32'h00A5_0034) begin
         n_err++; $display("FAIL gp_o_word2: got %h want 00a50034", gp_o[DW-1:0]); end
      do_read(BASE + 40'h8, d, lat, wok);
      n_cmp++; if (d !== 32'h00A5_0034) begin n_err++; $display("FAIL gp_read: got %h want 00a50034", d); end
      n_cmp++; if (lat != RD_LAT || !wok) begin
         n_err++; $display("FAIL gp_latency: got lat %0d wait_ok %0d want %0d 1", lat, wok, RD_LAT); end
      n_cmp++; if (rd_ack !== 1'b0) begin n_err++; $display("FAIL gp_ack_width: got %b want 0", rd_ack); end
   endtask

   task automatic test_start();
      logic [DW-1:0] d; int lat; bit wok, ack, wt;
      busy = 1'b0;
      do_write(BASE, 32'h3, 4'b0001, ack, wt);
      n_cmp++; if (start_o !== 1'b1) begin n_err++; $display("FAIL start_pulse: got %b want 1", start_o); end
      tick();
      n_cmp++; if (start_o !== 1'b0) begin n_err++; $display("FAIL start_one_cycle: got %b want 0", start_o); end
      done_in = 1'b1; tick(); done_in = 1'b0;
      n_cmp++; if (irq_o !== m_irq) begin n_err++; $display("FAIL irq_lag: got %b want %b", irq_o, m_irq); end
      tick();
      n_cmp++; if (irq_o !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b want 1", irq_o); end
      do_read(BASE + 40'h4, d, lat, wok);
      n_cmp++; if (d !== 32'h2) begin n_err++; $display("FAIL status_done: got %h want 2", d); end
      do_write(BASE + 40'h4, 32'h2, 4'b0001, ack, wt);
      tick();
      n_cmp++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b want 0", irq_o); end
      do_read(BASE + 40'h4, d, lat, wok);
      n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL status_w1c: got %h want 0", d); end
   endtask

   task automatic test_error();
      logic [DW-1:0] d; int lat; bit wok, ack, wt;
      busy = 1'b1;
      do_write(BASE, 32'h1, 4'b0001, ack, wt);
      n_cmp++; if (start_o !== 1'b0) begin n_err++; $display("FAIL err_no_start: got %b want 0", start_o); end
      do_read(BASE + 40'h4, d, lat, wok);
      n_cmp++; if (d !== 32'h5) begin n_err++; $display("FAIL status_err: got %h want 5", d); end
      done_in = 1'b1;
      do_write(BASE + 40'h4, 32'h2, 4'b0001, ack, wt);
      done_in = 1'b0;
      do_read(BASE + 40'h4, d, lat, wok);
      n_cmp++; if (d !== 32'h7) begin n_err++; $display("FAIL done_beats_w1c: got %h want 7", d); end
      do_write(BASE + 40'h4, 32'h6, 4'b1110, ack, wt);
      do_read(BASE + 40'h4, d, lat, wok);
      n_cmp++; if (d !== 32'h7) begin n_err++; $display("FAIL w1c_needs_strb0: got %h want 7", d); end
      do_write(BASE + 40'h4, 32'h4, 4'b0001, ack, wt);
      do_read(BASE + 40'h4, d, lat, wok);
      n_cmp++; if (d !== 32'h3) begin n_err++; $display("FAIL err_w1c: got %h want 3", d); end
      busy = 1'b0;
      do_write(BASE + 40'h4, 32'h2, 4'b0001, ack, wt);
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] exp; int c;
      rd_addr = BASE + 40'h8; rd_en = 1'b1; #1;
      exp = model_read(rd_addr);
      c = 0; while (!rd_ack && c < 20) begin tick(); c++; end
      n_cmp++; if (c != RD_LAT || rd_data !== exp) begin
         n_err++; $display("FAIL b2b_first: got lat %0d data %h want %0d %h", c, rd_data, RD_LAT, exp); end
      tick();
      n_cmp++; if (rd_ack !== 1'b0 || rd_wait !== 1'b1) begin
         n_err++; $display("FAIL b2b_reaccept: got ack %b wait %b want 0 1", rd_ack, rd_wait); end
      c = 0; while (!rd_ack && c < 20) begin tick(); c++; end
      n_cmp++; if (c != RD_LAT || rd_data !== exp) begin
         n_err++; $display("FAIL b2b_second: got lat %0d data %h want %0d %h", c, rd_data, RD_LAT, exp); end
      rd_en = 1'b0; tick();
   endtask

   task automatic test_range();
      logic [DW-1:0] d; int lat; bit wok, ack, wt;
      do_read(BASE + 40'h40, d, lat, wok);
      n_cmp++; if (d !== '0 || lat != RD_LAT) begin
         n_err++; $display("FAIL oor_read: got %h lat %0d want 0 lat %0d", d, lat, RD_LAT); end
      do_read(BASE - 40'h4, d, lat, wok);
      n_cmp++; if (d !== '0 || lat != RD_LAT) begin
         n_err++; $display("FAIL below_base_read: got %h lat %0d want 0 lat %0d", d, lat, RD_LAT); end
      do_write(BASE + 40'h40, 32'hFFFF_FFFF, 4'hF, ack, wt);
      n_cmp++; if (ack !== 1'b1 || gp_o !== exp_gp() || gp_o[DW-1:0] !== 32'h00A5_0034) begin
         n_err++; $display("FAIL oor_write: got ack %b gp %h want 1 %h", ack, gp_o, exp_gp()); end
      do_write(BASE + 40'h3F, 32'hDEAD_BEEF, 4'hF, ack, wt);
      n_cmp++; if (gp_o[NG*DW-1 -: DW] !== 32'hDEAD_BEEF) begin
         n_err++; $display("FAIL last_word_write: got %h want deadbeef", gp_o[NG*DW-1 -: DW]); end
      do_read(BASE + 40'h3D, d, lat, wok);
      n_cmp++; if (d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL low_bits_ignored: got %h want deadbeef", d); end
   endtask

   task automatic test_abort();
      logic [DW-1:0] d; int lat, acks; bit wok;
      rd_addr = BASE + 40'h8; rd_en = 1'b1;
      tick(); tick(); rd_en = 1'b0;
      acks = 0; repeat (RD_LAT + 4) begin tick(); if (rd_ack) acks++; end
      n_cmp++; if (acks != 0) begin n_err++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
      do_read(BASE + 40'h8, d, lat, wok);
      n_cmp++; if (d !== model_read(BASE + 40'h8) || lat != RD_LAT || !wok) begin
         n_err++; $display("FAIL after_abort: got %h lat %0d want %h lat %0d", d, lat, model_read(BASE + 40'h8), RD_LAT); end
      rd_en = 1'b1; tick(); tick();
      rstn = 1'b0; tick(); rstn = 1'b1; rd_en = 1'b0;
      acks = 0; repeat (RD_LAT + 4) begin if (rd_ack) acks++; tick(); end
      n_cmp++; if (acks != 0 || gp_o !== '0) begin
         n_err++; $display("FAIL reset_drops_read: got %0d acks gp %h want 0 acks gp 0", acks, gp_o); end
   endtask

   task automatic test_random();
      logic [DW-1:0] d, exp; int lat; bit wok;
      logic [AW-1:0] a;
      repeat (200) begin
         a = BASE + AW'(4 * $urandom_range(0, NR + 1)) + AW'($urandom_range(0, 3));
         busy = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 4) == 0) begin
            exp = model_read(a);
            do_read(a, d, lat, wok);
            n_cmp++; if (d !== exp || lat != RD_LAT) begin
               n_err++; $display("FAIL rand_read @%h: got %h lat %0d want %h lat %0d", a, d, lat, exp, RD_LAT); end
         end else begin
            done_in = ($urandom_range(0, 5) == 0);
            wr_en = ($urandom_range(0, 3) != 0); wr_addr = a;
            wr_data = $urandom; wr_strb = 4'($urandom_range(0, 15));
            tick();
            wr_en = 1'b0; done_in = 1'b0;
         end
         n_cmp++; if (start_o !== m_start || irq_o !== m_irq || gp_o !== exp_gp()) begin
            n_err++; $display("FAIL rand_state: got start %b irq %b gp %h want %b %b %h",
                              start_o, irq_o, gp_o, m_start, m_irq, exp_gp()); end
      end
      busy = 1'b0;
   endtask

   initial begin
      test_reset();
      test_gp();
      test_start();
      test_error();
      test_back_to_back();
      test_range();
      test_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
